fifo_sync_param: RTL and testbench

FIFO_SYNC_PARAM -- requirements
Module: fifo_sync_param

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_ram.sv | 28 ++
 rtl/fifo_sync_param.sv | 107 ++++++++++
 tb/tb_fifo_sync_param.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO: pointer/count width helpers
// and the read-mode selector constants.
package fifo_pkg;

   localparam int FWFT_OFF = 0;
   localparam int FWFT_ON  = 1;

   // Pointer width for a DEPTH-entry store; count needs one more bit to reach DEPTH.
   function automatic int addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int count_w(input int depth);
      return addr_w(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// DATA_W x DEPTH storage with one synchronous write port and one
// asynchronous read port; contents are intentionally left unreset.
module fifo_ram
   import fifo_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 32,
   localparam int AW    = addr_w(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with occupancy count, threshold flags, sticky error flags
// and a selectable registered or first-word-fall-through read port.
module fifo_sync_param
   import fifo_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 32,
   parameter int AF_LEVEL = DEPTH - 4,
   parameter int AE_LEVEL = 4,
   parameter int FWFT     = FWFT_OFF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_en,
   input  logic [DATA_W-1:0]         wr_data,
   input  logic                      rd_en,
   input  logic                      err_clr,
   output logic [DATA_W-1:0]         rd_data,
   output logic                      full,
   output logic                      empty,
   output logic                      almost_full,
   output logic                      almost_empty,
   output logic [count_w(DEPTH)-1:0] count,
   output logic                      overflow,
   output logic                      underflow
);

   localparam int AW = addr_w(DEPTH);
   localparam int CW = count_w(DEPTH);

   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic [DATA_W-1:0] ram_rdata;
   logic              wr_ok, rd_ok;

   // Flags come straight off the registered count so they track it with no lag.
   assign full         = (count_q == CW'(DEPTH));
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= CW'(AF_LEVEL));
   assign almost_empty = (count_q <= CW'(AE_LEVEL));
   assign count        = count_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   assign wr_ok = wr_en && !full;
   assign rd_ok = rd_en && !empty;

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      rd_data_d = rd_data_q;
      if (wr_ok) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (rd_ok) begin
         rd_ptr_d  = rd_ptr_q + AW'(1);
         rd_data_d = ram_rdata;
      end
      case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      // A fresh error event wins over a coincident clear.
      overflow_d  = (wr_en && full)  || (overflow_q  && !err_clr);
      underflow_d = (rd_en && empty) || (underflow_q && !err_clr);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         rd_data_q   <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
         rd_data_q   <= rd_data_d;
      end
   end

   // Storage write is gated by reset so requests in a reset cycle leave memory alone.
   fifo_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (wr_ok && !rst),
      .waddr (wr_ptr_q),
      .wdata (wr_data),
      .raddr (rd_ptr_q),
      .rdata (ram_rdata)
   );

   assign rd_data = (FWFT == FWFT_ON) ? ram_rdata : rd_data_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench: drives a registered-read and an FWFT FIFO with the same
// stimulus and compares both against a queue-based model every cycle.
module tb_fifo_sync_param;

   localparam int DEPTH  = 32;
   localparam int AF_LVL = 28;
   localparam int AE_LVL = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = '0;
   logic       rd_en = 1'b0;
   logic       err_clr = 1'b0;

   logic [7:0] rd_data0, rd_data1;
   logic       full0, empty0, af0, ae0, ovf0, udf0;
   logic       full1, empty1, af1, ae1, ovf1, udf1;
   logic [5:0] count0, count1;

   int checkCount = 0;
   int passCount  = 0;

   logic [7:0] mq[$];
   bit         mOvf = 1'b0;
   bit         mUdf = 1'b0;
   logic [7:0] mRd  = '0;
   bit         modelValid = 1'b0;
   int         mN;
   bit         mDoWr, mDoRd;

   always #5 clk = ~clk;

   fifo_sync_param #(.DATA_W(8), .DEPTH(DEPTH), .FWFT(0)) dut_reg (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .err_clr(err_clr), .rd_data(rd_data0), .full(full0), .empty(empty0),
      .almost_full(af0), .almost_empty(ae0), .count(count0),
      .overflow(ovf0), .underflow(udf0)
   );

   fifo_sync_param #(.DATA_W(8), .DEPTH(DEPTH), .FWFT(1)) dut_fwft (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .err_clr(err_clr), .rd_data(rd_data1), .full(full1), .empty(empty1),
      .almost_full(af1), .almost_empty(ae1), .count(count1),
      .overflow(ovf1), .underflow(udf1)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checkCount++;
      if (act === exp) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic applyStimulus(input logic w, input logic [7:0] d, input logic r,
                                input logic c, input logic rs);
      wr_en   = w;
      wr_data = d;
      rd_en   = r;
      err_clr = c;
      rst     = rs;
      @(posedge clk);
      #1;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      err_clr = 1'b0;
      rst     = 1'b0;
   endtask

   // Reference model: a plain queue whose size is the occupancy.
   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         mOvf = 1'b0;
         mUdf = 1'b0;
         mRd  = '0;
         modelValid = 1'b1;
      end else if (modelValid) begin
         mN    = mq.size();
         mDoWr = wr_en && (mN < DEPTH);
         mDoRd = rd_en && (mN > 0);
         mOvf  = (wr_en && mN == DEPTH) || (mOvf && !err_clr);
         mUdf  = (rd_en && mN == 0) || (mUdf && !err_clr);
         if (mDoRd) mRd = mq.pop_front();
         if (mDoWr) mq.push_back(wr_data);
      end
   end

   // Compare both instances against the model, away from the active edge.
   always @(negedge clk) begin
      if (modelValid) begin
         checkOutput("count0", 32'(count0), 32'(mq.size()));
         checkOutput("count1", 32'(count1), 32'(mq.size()));
         checkOutput("full0",  32'(full0),  32'(mq.size() == DEPTH));
         checkOutput("full1",  32'(full1),  32'(mq.size() == DEPTH));
         checkOutput("empty0", 32'(empty0), 32'(mq.size() == 0));
         checkOutput("empty1", 32'(empty1), 32'(mq.size() == 0));
         checkOutput("af0",    32'(af0),    32'(mq.size() >= AF_LVL));
         checkOutput("ae0",    32'(ae0),    32'(mq.size() <= AE_LVL));
         checkOutput("af1",    32'(af1),    32'(mq.size() >= AF_LVL));
         checkOutput("ae1",    32'(ae1),    32'(mq.size() <= AE_LVL));
         checkOutput("ovf0",   32'(ovf0),   32'(mOvf));
         checkOutput("udf0",   32'(udf0),   32'(mUdf));
         checkOutput("ovf1",   32'(ovf1),   32'(mOvf));
         checkOutput("udf1",   32'(udf1),   32'(mUdf));
         checkOutput("rd_data_reg", 32'(rd_data0), 32'(mRd));
         if (mq.size() > 0) checkOutput("rd_data_fwft", 32'(rd_data1), 32'(mq[0]));
      end
   end

   initial begin
      int wgt;
      int rdw;

      // Reset state
      applyStimulus(0, 8'h00, 0, 0, 1);
      applyStimulus(0, 8'h00, 0, 0, 1);
      checkOutput("rst_count", 32'(count0), 32'd0);
      checkOutput("rst_empty", 32'(empty0), 32'd1);
      checkOutput("rst_ae", 32'(ae0), 32'd1);
      checkOutput("rst_full", 32'(full0), 32'd0);
      checkOutput("rst_af", 32'(af0), 32'd0);
      checkOutput("rst_flags", 32'({ovf0, udf0}), 32'd0);
      checkOutput("rst_rd_data", 32'(rd_data0), 32'd0);

      // Fill with 0x01..0x20, then one write too many
      for (int i = 1; i <= 32; i++) begin
         applyStimulus(1, 8'(i), 0, 0, 0);
         if (i == 27) checkOutput("af_at_27", 32'(af0), 32'd0);
         if (i == 28) checkOutput("af_at_28", 32'(af0), 32'd1);
         if (i == 31) checkOutput("full_at_31", 32'(full0), 32'd0);
      end
      checkOutput("full_at_32", 32'(full0), 32'd1);
      checkOutput("count_at_32", 32'(count0), 32'd32);
      applyStimulus(1, 8'h21, 0, 0, 0);
      checkOutput("ovf_33rd", 32'(ovf0), 32'd1);
      checkOutput("count_33rd", 32'(count0), 32'd32);

      // Drain in order, then one read too many
      for (int i = 1; i <= 32; i++) begin
         applyStimulus(0, 8'h00, 1, 0, 0);
         checkOutput("drain_data", 32'(rd_data0), 32'(i));
      end
      checkOutput("drain_empty", 32'(empty0), 32'd1);
      applyStimulus(0, 8'h00, 1, 0, 0);
      checkOutput("udf_extra", 32'(udf0), 32'd1);
      checkOutput("hold_0x20", 32'(rd_data0), 32'h20);
      applyStimulus(0, 8'h00, 0, 1, 0);
      checkOutput("clr_flags", 32'({ovf0, udf0}), 32'd0);

      // Wrap: steady occupancy of 3 across 100 simultaneous cycles
      for (int i = 0; i < 3; i++) applyStimulus(1, 8'(i), 0, 0, 0);
      for (int j = 0; j < 100; j++) begin
         applyStimulus(1, 8'(j + 3), 1, 0, 0);
         checkOutput("wrap_count", 32'(count0), 32'd3);
         checkOutput("wrap_data", 32'(rd_data0), 32'(j));
      end
      for (int i = 0; i < 3; i++) applyStimulus(0, 8'h00, 1, 0, 0);
      checkOutput("wrap_last", 32'(rd_data0), 32'd102);

      // Simultaneous request on empty: write wins, underflow flagged
      applyStimulus(1, 8'hA5, 1, 0, 0);
      checkOutput("both_empty_count", 32'(count0), 32'd1);
      checkOutput("both_empty_udf", 32'(udf0), 32'd1);
      checkOutput("fwft_a5", 32'(rd_data1), 32'hA5);
      applyStimulus(0, 8'h00, 1, 1, 0);

      // FWFT head appears without rd_en, rd_en then empties
      applyStimulus(1, 8'h5A, 0, 0, 0);
      checkOutput("fwft_5a", 32'(rd_data1), 32'h5A);
      checkOutput("reg_holds_a5", 32'(rd_data0), 32'hA5);
      applyStimulus(0, 8'h00, 1, 0, 0);
      checkOutput("fwft_empty", 32'(empty1), 32'd1);

      // Simultaneous request on full: read accepted alone, so occupancy drops by one
      for (int i = 0; i < 32; i++) applyStimulus(1, 8'(8'h80 + i), 0, 0, 0);
      applyStimulus(1, 8'hEE, 1, 0, 0);
      checkOutput("both_full_count", 32'(count0), 32'd31);
      checkOutput("both_full_ovf", 32'(ovf0), 32'd1);
      checkOutput("both_full_data", 32'(rd_data0), 32'h80);
      applyStimulus(1, 8'h9F, 0, 0, 0);
      applyStimulus(1, 8'hEE, 0, 1, 0);
      checkOutput("clr_vs_ovf", 32'(ovf0), 32'd1);

      // Reset in the middle of a burst at occupancy 10
      for (int i = 0; i < 22; i++) applyStimulus(0, 8'h00, 1, 0, 0);
      checkOutput("pre_rst_count", 32'(count0), 32'd10);
      applyStimulus(1, 8'h77, 1, 0, 1);
      checkOutput("mid_rst_count", 32'(count0), 32'd0);
      checkOutput("mid_rst_empty", 32'(empty0), 32'd1);
      checkOutput("mid_rst_flags", 32'({ovf0, udf0, af0, full0}), 32'd0);

      // Randomized traffic with fill, drain and balanced phases
      for (int i = 0; i < 3000; i++) begin
         wgt = (i / 200) % 3;
         rdw = (wgt == 0) ? 30 : (wgt == 1) ? 85 : 55;
         applyStimulus(($urandom_range(99) < ((wgt == 1) ? 30 : 70)) ? 1'b1 : 1'b0,
                       8'($urandom),
                       ($urandom_range(99) < rdw) ? 1'b1 : 1'b0,
                       ($urandom_range(99) < 5) ? 1'b1 : 1'b0,
                       ($urandom_range(299) == 0) ? 1'b1 : 1'b0);
      end

      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
